subservient_ram_arb: RTL
========================

# subservient_ram_arb

Parametrised shared-SRAM arbiter for the subservient SoC. It multiplexes a single simple-dual-port SRAM (width `sram_dw` of 8, 16 or 32) between the byte-serial register-file port of the SERV core and a 32-bit Wishbone data/instruction port. It serialises each Wishbone access into `32/sram_dw` SRAM beats and gives register-file writes strict priority. It stalls, not corrupts, an in-flight Wishbone beat sequence, and drives per-lane byte enables to the SRAM.

## Interface
- `depth`, 256: SRAM size in bytes; power of two, at least 4·(32/`sram_dw`).
- `sram_dw`, 8: SRAM data width; legal values 8, 16, 32.
- `aw`, `$clog2(depth)`: byte address width.
- Derived, not overridable: `nb` = 32/`sram_dw` (beats per word); `bw` = max(1, `$clog2(nb)`); `saw` = `aw`−`$clog2(sram_dw/8)` (SRAM word address width).

Ports:
- `i_clk` in 1: clock; everything is on the rising edge.
- `i_rst_n` in 1: asynchronous, active-low reset.
- `i_waddr` in `saw`: register-file write address.
- `i_wdata` in `sram_dw`: register-file write data.
- `i_wen` in 1: register-file write; always wins the SRAM.
- `i_raddr` in `saw`: register-file read address.
- `o_rdata` out `sram_dw`: equal to `i_sram_rdata`.
- `o_sram_waddr` out `saw`: SRAM write address.
- `o_sram_wdata` out `sram_dw`: SRAM write data.
- `o_sram_wen` out 1: SRAM write strobe.
- `o_sram_be` out `sram_dw/8`: SRAM byte-lane enables.
- `o_sram_raddr` out `saw`: SRAM read address.
- `i_sram_rdata` in `sram_dw`: SRAM read data, valid one cycle after the address is presented.
- `i_wb_adr` in `aw-2`: Wishbone word address (byte address bits `aw-1:2`).
- `i_wb_dat` in 32: Wishbone write data.
- `i_wb_sel` in 4: Wishbone byte selects.
- `i_wb_we` in 1: Wishbone write.
- `i_wb_stb` in 1: Wishbone strobe/cycle.
- `o_wb_rdt` out 32: Wishbone read data; valid only while `o_wb_ack` is high.
- `o_wb_ack` out 1: Wishbone acknowledge; a single-cycle pulse, registered.

## Operation
- **States.** IDLE, BEAT, ACK.
  - IDLE → BEAT when `i_wb_stb` is high and `o_wb_ack` is low. The beat may issue in the same cycle.
  - BEAT → ACK after beat `nb-1` has issued.
  - ACK → IDLE unconditionally.
- **Beat issue.** A beat issues in any cycle with `i_wb_stb` high, state not ACK, and `i_wen` low.
  - SRAM read and write addresses are `{i_wb_adr, cnt}`.
  - `o_sram_wdata` is `i_wb_dat[cnt*sram_dw +: sram_dw]`.
  - `o_sram_be` is the matching slice of `i_wb_sel`.
  - `o_sram_wen` is `i_wb_we & |be`.
  - `cnt` increments, wrapping to 0 after `nb-1`.
- **Otherwise.** The SRAM ports carry the register-file signals, with `o_sram_be` all ones and `o_sram_wen` equal to `i_wen`.
- **Register-file collision.** When `i_wen` is high during BEAT, the beat is withheld that cycle and `cnt` holds. There is no data loss; latency grows by one cycle per collision.
- **Read assembly.**
  - Flag `iss_q` and index `idx_q` register the issued beat.
  - When `iss_q` is high and `idx_q` is below `nb-1`, `i_sram_rdata` is captured into `rdt_q[idx_q*sram_dw +: sram_dw]`.
  - `o_wb_rdt` is `{i_sram_rdata, rdt_q[31-sram_dw:0]}`. When `nb`=1, it is `i_sram_rdata`.
- **Read-port contention.** While BEAT is issuing, register-file reads return Wishbone data. The core is stalled on `o_wb_ack`, so this is permitted.
- **Write beats with all selects clear** still consume their cycle; latency is fixed.

## Timing
- **Reset values.** State IDLE; `cnt`, `iss_q`, `idx_q`, `rdt_q` are 0; `o_wb_ack` is 0. The SRAM outputs follow the register-file inputs.
- **Reset mid-transaction.** The access is aborted and no ack is produced. The master must reissue. Partial SRAM writes already performed remain.
- **Latency.** With `i_wb_stb` rising in cycle 0 and no collisions, `o_wb_ack` is high in cycle `nb`: cycle 4 for 8-bit, 2 for 16-bit, 1 for 32-bit. Each `i_wen` cycle during BEAT adds one cycle.
- **Ack cycle.** No beat issues and no new transaction starts. The master drops `i_wb_stb` in the following cycle, or holds it to start the next access back-to-back in the cycle after ack.
- **`i_wen` in the ack cycle** proceeds normally.

## Structure
- Beat-count and width-legality checks live in `subservient_pkg` as the localparam function `sram_beats(dw)`. An elaboration-time assertion rejects `sram_dw` values outside {8, 16, 32}.
- No sub-module: the sequencer, mux and read assembler are one flat module.

## Test plan
- **8-bit word read.** `sram_dw`=8; SRAM bytes at 0x40..0x43 = 11,22,33,44; read `adr`=0x10 → ack in cycle 4, `o_wb_rdt`=0x44332211.
- **16-bit masked write.** `sram_dw`=16; write 0xAABBCCDD with `sel`=0b0110 to `adr`=0x02 → beat 0 has `be`=10, beat 1 has `be`=01; readback gives 0x??BBCC?? with the original bytes preserved.
- **Collision.** `sram_dw`=8; `i_wen` high in cycles 1 and 2 of a read → RF writes land at their addresses, ack in cycle 6, data correct.
- **Single-beat and back-to-back.** `sram_dw`=32; read → ack in cycle 1. Back-to-back reads with `stb` held → acks in cycles 1 and 3.
- **Zero-select write.** `sel`=0000 → `o_sram_wen` never asserted, ack still in cycle `nb`.
- **Reset abort.** `i_rst_n` low in cycle 2 of an 8-bit write → no ack, bytes 0–1 written, bytes 2–3 unchanged, outputs return to reset values asynchronously.

Source files
------------

// File: rtl/subservient_ram_arb_pkg.sv
// subservient_pkg: shared FSM type and SRAM width helper for the subservient RAM arbiter.
package subservient_pkg;

    typedef enum logic [1:0] {IDLE, BEAT, ACK} state_t;

    // Beats per 32-bit Wishbone word; 0 flags an unsupported SRAM width.
    function automatic int sram_beats(input int dw);
        return (dw == 8 || dw == 16 || dw == 32) ? 32 / dw : 0;
    endfunction

endpackage

// File: rtl/subservient_ram_arb.sv
// subservient_ram_arb: shares one SRAM between the SERV register file and a 32-bit Wishbone port,
// splitting each Wishbone access into sram_dw-wide beats and yielding to register-file writes.
module subservient_ram_arb
    import subservient_pkg::*;
#(
    parameter int depth = 256,
    parameter int sram_dw = 8,
    parameter int aw = $clog2(depth),
    localparam int nb = sram_beats(sram_dw),
    localparam int bw = nb > 1 ? $clog2(nb) : 1,
    localparam int saw = aw - $clog2(sram_dw / 8)
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic [saw-1:0]       i_waddr,
    input  logic [sram_dw-1:0]   i_wdata,
    input  logic                 i_wen,
    input  logic [saw-1:0]       i_raddr,
    output logic [sram_dw-1:0]   o_rdata,
    output logic [saw-1:0]       o_sram_waddr,
    output logic [sram_dw-1:0]   o_sram_wdata,
    output logic                 o_sram_wen,
    output logic [sram_dw/8-1:0] o_sram_be,
    output logic [saw-1:0]       o_sram_raddr,
    input  logic [sram_dw-1:0]   i_sram_rdata,
    input  logic [aw-3:0]        i_wb_adr,
    input  logic [31:0]          i_wb_dat,
    input  logic [3:0]           i_wb_sel,
    input  logic                 i_wb_we,
    input  logic                 i_wb_stb,
    output logic [31:0]          o_wb_rdt,
    output logic                 o_wb_ack
);

    state_t               state, state_nxt;
    logic [bw-1:0]        cnt, idx_q;
    logic                 iss_q, issue, last;
    logic [31:0]          rdt_q;
    logic [saw-1:0]       wb_addr;
    logic [sram_dw-1:0]   wb_wdata;
    logic [sram_dw/8-1:0] wb_be;

    if (nb == 0) begin : g_bad_width
        $error("subservient_ram_arb: sram_dw must be 8, 16 or 32");
    end

    if (nb == 1) begin : g_addr_word
        assign wb_addr  = i_wb_adr;
        assign o_wb_rdt = i_sram_rdata;
    end else begin : g_addr_beat
        assign wb_addr  = {i_wb_adr, cnt};
        assign o_wb_rdt = {i_sram_rdata, rdt_q[31-sram_dw:0]};
    end

    // Register-file writes own the SRAM; a blocked beat simply waits with cnt held.
    assign issue    = i_wb_stb && state != ACK && !i_wen;
    assign last     = cnt == bw'(nb - 1);
    assign wb_wdata = i_wb_dat[32'(cnt)*sram_dw +: sram_dw];
    assign wb_be    = i_wb_sel[32'(cnt)*(sram_dw/8) +: sram_dw/8];

    assign o_rdata      = i_sram_rdata;
    assign o_sram_waddr = issue ? wb_addr : i_waddr;
    assign o_sram_raddr = issue ? wb_addr : i_raddr;
    assign o_sram_wdata = issue ? wb_wdata : i_wdata;
    assign o_sram_be    = issue ? wb_be : '1;
    assign o_sram_wen   = issue ? i_wb_we && |wb_be : i_wen;

    always_comb begin
        state_nxt = state;
        state_nxt = (issue && last) ? ACK :
                    (state == ACK) ? IDLE :
                    (state == IDLE && i_wb_stb && !o_wb_ack) ? BEAT : state;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            iss_q    <= 1'b0;
            idx_q    <= '0;
            rdt_q    <= '0;
            o_wb_ack <= 1'b0;
        end else begin
            state    <= state_nxt;
            o_wb_ack <= issue && last;
            iss_q    <= issue;
            idx_q    <= cnt;
            if (issue)
                cnt <= last ? '0 : cnt + bw'(1);
            // The final beat is forwarded straight from the SRAM, so only earlier beats are held.
            if (iss_q && 32'(idx_q) < nb - 1)
                rdt_q[32'(idx_q)*sram_dw +: sram_dw] <= i_sram_rdata;
        end
    end

endmodule
